// File: rtl/weightmem_pkg.sv
// Shared types and helpers for the weight memory bank scheduler.
package weightmem_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} wms_state_e;

  // Encoded-trit word width: 5 trits pack into 8 bits.
  function automatic int word_bits(int n_i, int weight_stagger);
    return ((n_i / weight_stagger + 4) / 5) * 8;
  endfunction

  // Modular add for operands already below depth (single subtract is enough).
  function automatic int wrap_add(int a, int b, int depth);
    int s;
    s = a + b;
    return (s >= depth) ? s - depth : s;
  endfunction

endpackage

// File: rtl/weightmem_arbiter.sv
// Per-cycle grant of the single bank port between host writes and job reads,
// with a write-burst limit so a pending read cannot be starved.
module weightmem_arbiter
  import weightmem_pkg::*;
#(
  parameter int WRITE_BURST = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_read_i,
  input  logic clear_i,
  input  logic wr_valid_i,
  input  logic rd_want_i,
  output logic wr_grant_o,
  output logic rd_grant_o
);

  localparam int WBW = $clog2(WRITE_BURST + 1);
  localparam logic [WBW-1:0] WB_MAX = WBW'(WRITE_BURST);

  logic [WBW-1:0] wburst_q, wburst_d;

  always_comb begin
    wr_grant_o = 1'b0;
    rd_grant_o = 1'b0;
    if (!in_read_i) begin
      wr_grant_o = wr_valid_i;
    end else begin
      wr_grant_o = wr_valid_i & (!rd_want_i | (wburst_q < WB_MAX));
      rd_grant_o = rd_want_i & !wr_grant_o;
    end
  end

  always_comb begin
    wburst_d = wburst_q;
    if (clear_i || rd_grant_o) begin
      wburst_d = '0;
    end else if (wr_grant_o && rd_want_i && in_read_i) begin
      wburst_d = wburst_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wburst_q <= '0;
    else         wburst_q <= wburst_d;
  end

endmodule

// File: rtl/weightmem_scheduler.sv
// Sequences a burst read job against one weight memory bank while interleaving
// host weight writes; the bank never sees read and write enables together.
module weightmem_scheduler
  import weightmem_pkg::*;
#(
  parameter int N_I            = 512,
  parameter int WEIGHT_STAGGER = 8,
  parameter int BANKDEPTH      = 90,
  parameter int WORDBITS       = word_bits(N_I, WEIGHT_STAGGER),
  parameter int WRITE_BURST    = 4,
  localparam int AW            = $clog2(BANKDEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [WORDBITS-1:0] wr_data_i,
  input  logic                job_valid_i,
  output logic                job_ready_o,
  input  logic [AW-1:0]       job_base_i,
  input  logic [AW:0]         job_len_i,
  input  logic                stall_i,
  output logic                mem_read_enable_o,
  output logic                mem_write_enable_o,
  output logic [AW-1:0]       mem_addr_o,
  output logic [WORDBITS-1:0] mem_wdata_o,
  input  logic                mem_ready_i,
  input  logic                mem_collision_i,
  output logic                rd_valid_o,
  output logic                rd_last_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(BANKDEPTH);

  wms_state_e    state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   issued_q, issued_d;
  logic [AW:0]   returned_q, returned_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] mem_addr_q;
  logic          rd_pend_q;
  logic          err_q;

  logic          wr_grant, rd_grant, rd_want, job_start, wr_addr_ok;
  logic [AW:0]   job_len_clip;

  assign job_len_clip = (job_len_i > DEPTH_L) ? DEPTH_L : job_len_i;
  assign rd_want      = (state_q == READ) && !stall_i && (issued_q < len_q);
  assign wr_addr_ok   = ({1'b0, wr_addr_i} < DEPTH_L);

  weightmem_arbiter #(
    .WRITE_BURST(WRITE_BURST)
  ) u_arbiter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_read_i  (state_q == READ),
    .clear_i    (job_start),
    .wr_valid_i (wr_valid_i),
    .rd_want_i  (rd_want),
    .wr_grant_o (wr_grant),
    .rd_grant_o (rd_grant)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    returned_d = rd_pend_q ? returned_q + 1'b1 : returned_q;
    rd_addr_d  = rd_addr_q;
    job_start  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (job_valid_i) begin
          job_start  = 1'b1;
          len_d      = job_len_clip;
          issued_d   = '0;
          returned_d = '0;
          // Bases above the bank depth fold back into range once.
          rd_addr_d  = AW'(wrap_add(int'(job_base_i), 0, BANKDEPTH));
          state_d    = (job_len_clip == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (rd_grant) begin
          issued_d  = issued_q + 1'b1;
          rd_addr_d = AW'(wrap_add(int'(rd_addr_q), 1, BANKDEPTH));
          if (issued_q + 1'b1 == len_q) state_d = DRAIN;
        end
      end
      DRAIN:   if (rd_pend_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      rd_addr_q  <= '0;
      mem_addr_q <= '0;
      rd_pend_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      rd_addr_q  <= rd_addr_d;
      mem_addr_q <= mem_addr_o;
      rd_pend_q  <= rd_grant;
      if (mem_collision_i || (wr_grant && !wr_addr_ok)) err_q <= 1'b1;
    end
  end

  assign wr_ready_o         = wr_grant;
  assign mem_write_enable_o = wr_grant & wr_addr_ok;
  assign mem_read_enable_o  = rd_grant;
  assign mem_addr_o         = wr_grant ? wr_addr_i : (rd_grant ? rd_addr_q : mem_addr_q);
  assign mem_wdata_o        = wr_data_i;
  assign rd_valid_o         = rd_pend_q & mem_ready_i;
  assign rd_last_o          = rd_valid_o & (returned_q == len_q - 1'b1);
  assign busy_o             = (state_q != IDLE);
  assign job_ready_o        = (state_q == IDLE);
  assign done_o             = (state_q == DONE);
  assign err_o              = err_q;

endmodule
